// File: rtl/uc_seq.sv
// uc_seq: sequenced control unit for the single-cycle datapath.
// Decodes opcode/z into datapath strobes, stalls IN/OUT until the port is
// ready (bounded by IO_TIMEOUT), tracks call/data stack depth and halts.
// Optional macro UC_STACK_GUARD_EN: when defined, stack over/underflow
// instructions are suppressed and flagged in err[1].
module uc_seq #(
    parameter int CALL_DEPTH = 16,
    parameter int DATA_DEPTH = 64,
    parameter int IO_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       io_ready,
    output logic       s_inc,
    output logic       pc_en,
    output logic       we3,
    output logic       wez,
    output logic       s_we_port,
    output logic       s_we_stack,
    output logic       s_jalret,
    output logic       s_we_stack_data,
    output logic       s_pushpop,
    output logic [2:0] op_alu,
    output logic [1:0] sel_inputs,
    output logic       halted,
    output logic [2:0] err
);

    localparam int CW = $clog2(CALL_DEPTH + 1);
    localparam int DW = $clog2(DATA_DEPTH + 1);
    localparam logic [CW-1:0] CALL_MAX = CW'(CALL_DEPTH);
    localparam logic [DW-1:0] DATA_MAX = DW'(DATA_DEPTH);
    localparam logic [7:0]    IO_TO    = 8'(IO_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_IO_WAIT = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    state_t        r_state;
    logic [7:0]    r_wait_cnt;
    logic [CW-1:0] r_call_cnt;
    logic [DW-1:0] r_data_cnt;
    logic [2:0]    r_err;

    // raw decode results
    logic       w_d_inc, w_d_we3, w_d_wez, w_d_we_port, w_d_we_stack;
    logic       w_d_jalret, w_d_we_sd, w_d_pushpop;
    logic [2:0] w_d_alu;
    logic [1:0] w_d_sel;
    logic       w_is_io, w_is_jal, w_is_ret, w_is_push, w_is_pop;
    logic       w_is_halt, w_is_illegal;

    // stack guard blocking conditions
    logic w_blk_jal, w_blk_ret, w_blk_push, w_blk_pop, w_blocked;

    // decode after the stack guard has been applied
    logic w_g_inc, w_g_we3, w_g_we_stack, w_g_we_sd;

    // IO_WAIT completes on ready or when the wait budget is used up
    logic w_io_done;

    // Instruction decode: opcode and z to raw strobes and class flags.
    always_comb begin
        w_d_inc      = 1'b1;
        w_d_we3      = 1'b0;
        w_d_wez      = 1'b0;
        w_d_we_port  = 1'b0;
        w_d_we_stack = 1'b0;
        w_d_jalret   = 1'b0;
        w_d_we_sd    = 1'b0;
        w_d_pushpop  = 1'b0;
        w_d_alu      = 3'b000;
        w_d_sel      = 2'b00;
        w_is_io      = 1'b0;
        w_is_jal     = 1'b0;
        w_is_ret     = 1'b0;
        w_is_push    = 1'b0;
        w_is_pop     = 1'b0;
        w_is_halt    = 1'b0;
        w_is_illegal = 1'b0;
        casez (opcode)
            6'b0?????: begin
                w_d_we3 = 1'b1;
                w_d_wez = 1'b1;
                w_d_alu = opcode[4:2];
            end
            6'b1000??: begin
                w_d_we3 = 1'b1;
                w_d_sel = 2'b11;
            end
            6'b100100: begin
                w_d_we3 = 1'b1;
                w_d_sel = 2'b01;
                w_is_io = 1'b1;
            end
            6'b100101: begin
                w_d_we_port = 1'b1;
                w_is_io     = 1'b1;
            end
            6'b100110: begin
                w_d_we_sd   = 1'b1;
                w_d_pushpop = 1'b1;
                w_is_push   = 1'b1;
            end
            6'b100111: begin
                w_d_we_sd   = 1'b1;
                w_d_pushpop = 1'b0;
                w_d_we3     = 1'b1;
                w_d_sel     = 2'b10;
                w_is_pop    = 1'b1;
            end
            6'b101000: w_d_inc = 1'b0;
            6'b101001: w_d_inc = ~z;
            6'b101010: w_d_inc = z;
            6'b101011: begin
                w_d_inc      = 1'b0;
                w_d_we_stack = 1'b1;
                w_d_jalret   = 1'b0;
                w_is_jal     = 1'b1;
            end
            6'b101100: begin
                w_d_inc      = 1'b0;
                w_d_we_stack = 1'b1;
                w_d_jalret   = 1'b1;
                w_is_ret     = 1'b1;
            end
            6'b111111: w_is_halt = 1'b1;
            default:   w_is_illegal = 1'b1;
        endcase
    end

`ifdef UC_STACK_GUARD_EN
    assign w_blk_jal  = w_is_jal  && (r_call_cnt == CALL_MAX);
    assign w_blk_ret  = w_is_ret  && (r_call_cnt == {CW{1'b0}});
    assign w_blk_push = w_is_push && (r_data_cnt == DATA_MAX);
    assign w_blk_pop  = w_is_pop  && (r_data_cnt == {DW{1'b0}});
`else
    assign w_blk_jal  = 1'b0;
    assign w_blk_ret  = 1'b0;
    assign w_blk_push = 1'b0;
    assign w_blk_pop  = 1'b0;
`endif

    assign w_blocked    = w_blk_jal | w_blk_ret | w_blk_push | w_blk_pop;
    // a blocked JAL/RET degrades to a NOP that falls through to PC+1
    assign w_g_inc      = w_d_inc | w_blk_jal | w_blk_ret;
    assign w_g_we_stack = w_d_we_stack & ~(w_blk_jal | w_blk_ret);
    assign w_g_we_sd    = w_d_we_sd & ~(w_blk_push | w_blk_pop);
    assign w_g_we3      = w_d_we3 & ~w_blk_pop;
    assign w_io_done    = io_ready || (r_wait_cnt == IO_TO);

    // Output strobes: guarded decode, gated by FSM state and reset.
    always_comb begin
        s_inc           = w_g_inc;
        pc_en           = 1'b1;
        we3             = w_g_we3;
        wez             = w_d_wez;
        s_we_port       = w_d_we_port;
        s_we_stack      = w_g_we_stack;
        s_jalret        = w_d_jalret;
        s_we_stack_data = w_g_we_sd;
        s_pushpop       = w_d_pushpop;
        op_alu          = w_d_alu;
        sel_inputs      = w_d_sel;
        halted          = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_is_io && !io_ready) begin
                    pc_en     = 1'b0;
                    we3       = 1'b0;
                    s_we_port = 1'b0;
                end else if (w_is_halt) begin
                    pc_en = 1'b0;
                end else begin
                    pc_en = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                if (w_io_done) begin
                    pc_en = 1'b1;
                end else begin
                    pc_en           = 1'b0;
                    we3             = 1'b0;
                    wez             = 1'b0;
                    s_we_port       = 1'b0;
                    s_we_stack      = 1'b0;
                    s_we_stack_data = 1'b0;
                end
            end
            default: begin
                // HALT (and any unreachable encoding): everything idle, PC frozen
                s_inc           = 1'b1;
                pc_en           = 1'b0;
                we3             = 1'b0;
                wez             = 1'b0;
                s_we_port       = 1'b0;
                s_we_stack      = 1'b0;
                s_jalret        = 1'b0;
                s_we_stack_data = 1'b0;
                s_pushpop       = 1'b0;
                op_alu          = 3'b000;
                sel_inputs      = 2'b00;
                halted          = (r_state == ST_HALT);
            end
        endcase
        if (reset) begin
            pc_en           = 1'b0;
            we3             = 1'b0;
            wez             = 1'b0;
            s_we_port       = 1'b0;
            s_we_stack      = 1'b0;
            s_we_stack_data = 1'b0;
        end else begin
            pc_en = pc_en;
        end
    end

    assign err = r_err;

    // Sequencer state, IO wait counter, stack depth counters and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_call_cnt <= {CW{1'b0}};
            r_data_cnt <= {DW{1'b0}};
            r_err      <= 3'b000;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_is_io && !io_ready) begin
                        r_state    <= ST_IO_WAIT;
                        r_wait_cnt <= 8'd0;
                    end else if (w_is_halt) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ready) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == IO_TO) begin
                        r_state  <= ST_RUN;
                        r_err[0] <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase

            // depth counters move only on committed, unblocked stack ops and saturate
            if (pc_en && w_is_jal && !w_blk_jal && (r_call_cnt != CALL_MAX)) begin
                r_call_cnt <= r_call_cnt + {{(CW-1){1'b0}}, 1'b1};
            end else if (pc_en && w_is_ret && !w_blk_ret && (r_call_cnt != {CW{1'b0}})) begin
                r_call_cnt <= r_call_cnt - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                r_call_cnt <= r_call_cnt;
            end

            if (pc_en && w_is_push && !w_blk_push && (r_data_cnt != DATA_MAX)) begin
                r_data_cnt <= r_data_cnt + {{(DW-1){1'b0}}, 1'b1};
            end else if (pc_en && w_is_pop && !w_blk_pop && (r_data_cnt != {DW{1'b0}})) begin
                r_data_cnt <= r_data_cnt - {{(DW-1){1'b0}}, 1'b1};
            end else begin
                r_data_cnt <= r_data_cnt;
            end

            if ((r_state == ST_RUN) && w_is_illegal) begin
                r_err[2] <= 1'b1;
            end else begin
                r_err[2] <= r_err[2];
            end

            if ((r_state == ST_RUN) && w_blocked) begin
                r_err[1] <= 1'b1;
            end else begin
                r_err[1] <= r_err[1];
            end
        end
    end

endmodule
